// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
   localparam int          FETCH_DEC_WIDTH = 64;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - single-outstanding instruction-memory request/response bus
interface fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter with reset load, +4 advance and redirect load
module pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] req_pc
);

   // Redirect wins over advance; req_pc remembers the address of the granted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else begin
         if (redirect) begin
            pc <= redirect_pc & ~32'd3;
         end else if (advance) begin
            pc <= pc + 32'd4;
         end
         if (advance) begin
            req_pc <= pc;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction-fetch stage feeding the fetch/decode register
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 stall,
   input  logic                                 redirect,
   input  logic [31:0]                          redirect_pc,
   fetch_stage_if.master                        imem,
   output logic [fetch_pkg::FETCH_DEC_WIDTH-1:0] fetch_dec_reg,
   output logic                                 fetch_dec_valid
);

   import fetch_pkg::*;

   localparam logic [FETCH_DEC_WIDTH-1:0] BUBBLE = {NOP_INSTR, 32'h0000_0000};

   fetch_state_t               state;
   logic                       drop;
   logic [FETCH_DEC_WIDTH-1:0] hold;
   logic [31:0]                pc;
   logic [31:0]                req_pc;
   logic                       advance;

   assign advance = (state == REQ) && imem.imem_gnt;

   pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .advance     (advance),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .req_pc      (req_pc)
   );

   assign imem.imem_req  = (state == REQ);
   assign imem.imem_addr = pc;

   // Fetch FSM: redirect flushes first, otherwise request, wait, and park data while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         drop            <= 1'b0;
         hold            <= '0;
         fetch_dec_reg   <= BUBBLE;
         fetch_dec_valid <= 1'b0;
      end else if (redirect) begin
         fetch_dec_reg   <= BUBBLE;
         fetch_dec_valid <= 1'b0;
         hold            <= '0;
         case (state)
            REQ: begin
               if (imem.imem_gnt) begin
                  drop  <= 1'b1;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  drop  <= 1'b0;
                  state <= REQ;
               end else begin
                  drop <= 1'b1;
               end
            end
            default: state <= REQ;
         endcase
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (imem.imem_gnt) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else if (!stall) begin
                     fetch_dec_reg   <= {imem.imem_rdata, req_pc};
                     fetch_dec_valid <= 1'b1;
                     state           <= REQ;
                  end else begin
                     hold  <= {imem.imem_rdata, req_pc};
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  fetch_dec_reg   <= hold;
                  fetch_dec_valid <= 1'b1;
                  state           <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

   import fetch_pkg::*;

   localparam logic [64:0] RST_VAL = {1'b0, 32'h0000_0013, 32'h0000_0000};
   localparam logic [31:0] I0   = 32'h0050_0093;
   localparam logic [31:0] I1   = 32'h00A0_0113;
   localparam logic [31:0] I2   = 32'h0030_0193;
   localparam logic [31:0] I100 = 32'h0010_0213;
   localparam logic [31:0] I104 = 32'h0020_0293;
   localparam logic [31:0] I200 = 32'h0040_0313;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [63:0] dec_reg;
   logic        dec_valid;
   logic [63:0] dec_reg2;
   logic        dec_valid2;

   fetch_stage_if imem ();
   fetch_stage_if imem2 ();

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem            (imem),
      .fetch_dec_reg   (dec_reg),
      .fetch_dec_valid (dec_valid)
   );

   fetch_stage #(
      .RESET_PC (32'hFFFF_FFFC)
   ) dut2 (
      .clk             (clk),
      .rst             (rst),
      .stall           (1'b0),
      .redirect        (1'b0),
      .redirect_pc     (32'h0),
      .imem            (imem2),
      .fetch_dec_reg   (dec_reg2),
      .fetch_dec_valid (dec_valid2)
   );

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          stray = 0;
   logic        mon_en = 1'b0;
   logic        gnt_en = 1'b0;
   logic        resp_en = 1'b1;
   logic        pending = 1'b0;
   logic [31:0] paddr = 32'h0;
   logic [31:0] gaddr = 32'h0;
   logic [31:0] exp_addr_q[$];
   logic [64:0] exp_out_q[$];
   logic [64:0] exp_last = RST_VAL;
   int          pop_cyc[$];
   logic [31:0] wrap_q[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h000: return I0;
         32'h004: return I1;
         32'h008: return I2;
         32'h100: return I100;
         32'h104: return I104;
         32'h200: return I200;
         default: return {16'hBAD0, a[15:0]};
      endcase
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_out(input logic v, input logic [31:0] ins, input logic [31:0] p);
      exp_out_q.push_back({v, ins, p});
      exp_last = {v, ins, p};
   endtask

   task automatic wait_addr(input int n);
      int k = 0;
      while (exp_addr_q.size() > n && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      total++;
      if (exp_addr_q.size() > n) begin
         bad++;
         $display("FAIL addr_wait actual=%0d left required=%0d", exp_addr_q.size(), n);
         exp_addr_q.delete();
      end
   endtask

   task automatic wait_out();
      int k = 0;
      while (exp_out_q.size() > 0 && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      total++;
      if (exp_out_q.size() > 0) begin
         bad++;
         $display("FAIL out_wait actual=%0d left required=0", exp_out_q.size());
         exp_out_q.delete();
      end
   endtask

   task automatic do_reset();
      gnt_en   = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      if (exp_last !== RST_VAL) push_out(1'b0, 32'h0000_0013, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", {64'h0, imem.imem_req}, 65'h0);
      chk("rst_out", {dec_valid, dec_reg}, RST_VAL);
      rst = 1'b0;
   endtask

   // memory model: grant while enabled, answer the granted address once resp_en allows
   initial begin
      imem.imem_gnt    = 1'b0;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (imem.imem_rvalid) pending = 1'b0;
         if (imem.imem_gnt) begin
            pending = 1'b1;
            paddr   = gaddr;
         end
         imem.imem_rvalid = pending && resp_en;
         imem.imem_rdata  = pending ? mem(paddr) : 32'h0;
         imem.imem_gnt    = imem.imem_req && gnt_en;
         gaddr            = imem.imem_addr;
      end
   end

   // zero-wait memory for the wrap instance
   initial begin
      imem2.imem_gnt    = 1'b0;
      imem2.imem_rvalid = 1'b0;
      imem2.imem_rdata  = 32'h0000_0013;
      forever begin
         @(posedge clk); #1;
         imem2.imem_rvalid = imem2.imem_gnt;
         imem2.imem_gnt    = imem2.imem_req;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mon_en && !rst && imem.imem_rvalid && dut.state != WAIT) stray++;
   end

   // request monitor
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && imem.imem_req && imem.imem_gnt) begin
            if (exp_addr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL imem_addr_extra actual=%h required=none", imem.imem_addr);
            end else begin
               e = exp_addr_q.pop_front();
               chk("imem_addr", {33'h0, imem.imem_addr}, {33'h0, e});
            end
         end
         if (mon_en && imem2.imem_req && imem2.imem_gnt && wrap_q.size() < 2)
            wrap_q.push_back(imem2.imem_addr);
      end
   end

   // decode-register monitor: every change must match the next expected entry
   initial begin
      logic [64:0] prev;
      logic [64:0] cur;
      logic [64:0] e;
      prev = RST_VAL;
      forever begin
         @(negedge clk);
         cur = {dec_valid, dec_reg};
         if (mon_en && cur !== prev) begin
            if (exp_out_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL dec_out_extra actual=%h required=none", cur);
            end else begin
               e = exp_out_q.pop_front();
               chk("dec_out", cur, e);
               pop_cyc.push_back(cyc);
            end
            prev = cur;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      do_reset();

      // zero-wait streaming
      pop_cyc.delete();
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      push_out(1'b1, I0, 32'h0);
      push_out(1'b1, I1, 32'h4);
      push_out(1'b1, I2, 32'h8);
      gnt_en = 1'b1;
      resp_en = 1'b1;
      wait_addr(0);
      gnt_en = 1'b0;
      wait_out();
      if (pop_cyc.size() >= 2) chk("throughput", 65'(pop_cyc[1] - pop_cyc[0]), 65'd2);
      else chk("throughput_cnt", 65'(pop_cyc.size()), 65'd3);

      // stall across the response for 0x4
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      push_out(1'b1, I0, 32'h0);
      push_out(1'b1, I1, 32'h4);
      push_out(1'b1, I2, 32'h8);
      gnt_en = 1'b1;
      wait_addr(1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_hold", {dec_valid, dec_reg}, {1'b1, I0, 32'h0});
      end
      stall = 1'b0;
      @(negedge clk);
      chk("stall_release", {dec_valid, dec_reg}, {1'b1, I1, 32'h4});
      wait_addr(0);
      gnt_en = 1'b0;
      wait_out();

      // redirect to 0x100 while waiting on 0x8
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
      push_out(1'b1, I0, 32'h0);
      push_out(1'b1, I1, 32'h4);
      push_out(1'b0, 32'h0000_0013, 32'h0);
      push_out(1'b1, I100, 32'h100);
      push_out(1'b1, I104, 32'h104);
      gnt_en = 1'b1;
      wait_addr(2);
      resp_en = 1'b0;
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect = 1'b0;
      resp_en  = 1'b1;
      chk("redir_bubble", {dec_valid, dec_reg}, RST_VAL);
      wait_addr(0);
      gnt_en = 1'b0;
      wait_out();

      // redirect to 0x203 with stall and grant in the same cycle
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h200};
      push_out(1'b1, I0, 32'h0);
      push_out(1'b0, 32'h0000_0013, 32'h0);
      push_out(1'b1, I200, 32'h200);
      gnt_en = 1'b1;
      wait_addr(1);
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      stall       = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      chk("redir_gnt_valid", {64'h0, dec_valid}, 65'h0);
      wait_addr(0);
      gnt_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("redir_stall_hold", {dec_valid, dec_reg}, RST_VAL);
      stall = 1'b0;
      wait_out();

      // reset while waiting, late response must be ignored
      do_reset();
      resp_en = 1'b0;
      exp_addr_q = '{32'h0};
      gnt_en = 1'b1;
      wait_addr(0);
      gnt_en = 1'b0;
      @(negedge clk);
      rst     = 1'b1;
      resp_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_req", {64'h0, imem.imem_req}, 65'h0);
      chk("mid_rst_out", {dec_valid, dec_reg}, RST_VAL);
      exp_addr_q = '{32'h0};
      push_out(1'b1, I0, 32'h0);
      gnt_en = 1'b1;
      wait_addr(0);
      gnt_en = 1'b0;
      wait_out();
      repeat (3) @(negedge clk);

      chk("stray_rvalid", 65'(stray), 65'd1);
      if (wrap_q.size() >= 2) begin
         chk("wrap_first", {33'h0, wrap_q[0]}, {33'h0, 32'hFFFF_FFFC});
         chk("wrap_second", {33'h0, wrap_q[1]}, 65'h0);
      end else begin
         chk("wrap_count", 65'(wrap_q.size()), 65'd2);
      end
      chk("addr_q_empty", 65'(exp_addr_q.size()), 65'd0);
      chk("out_q_empty", 65'(exp_out_q.size()), 65'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core.
- Owns the PC and drives a single-outstanding-request instruction-memory interface.
- Writes the fetch/decode pipeline register fetch_dec_reg = {instruction, pc} (64 bits) that the decode stage consumes.
- Handles hazard-unit stalls and branch/jump redirects from execute, inserting NOP bubbles on flush.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold fetch_dec_reg and fetch_dec_valid
redirect  in  1  execute: taken branch/jump, flush fetch
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
imem_req  out  1  request valid
imem_addr  out  32  request word address (byte address, 4-aligned)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
fetch_dec_reg  out  64  {instruction[63:32], pc[31:0]} to decode
fetch_dec_valid  out  1  fetch_dec_reg holds a real instruction

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - pc=RESET_PC, state=IDLE, drop=0.
  - imem_req=0.
  - fetch_dec_reg={NOP_INSTR, 32'h0}, fetch_dec_valid=0.
  - hold buffer cleared.
- Reset mid-operation discards any outstanding request. An imem_rvalid arriving afterwards is ignored, since IDLE does not consume rvalid.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - imem_req=0.
  - Go to REQ the cycle after rst deasserts.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Both stay stable until imem_gnt, unless a redirect occurs.
  - On imem_gnt: req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), go WAIT.
- WAIT:
  - imem_req=0. Exactly one request is outstanding.
  - On imem_rvalid with drop=1: discard data, drop<=0, go REQ.
  - On imem_rvalid with drop=0 and stall=0: fetch_dec_reg<={imem_rdata, req_pc}, fetch_dec_valid<=1, go REQ.
  - On imem_rvalid with drop=0 and stall=1: hold<={imem_rdata, req_pc}, go HOLD.
- HOLD:
  - imem_req=0.
  - When stall=0: fetch_dec_reg<=hold, fetch_dec_valid<=1, go REQ.
- Stall rule: while stall=1 and no redirect, fetch_dec_reg and fetch_dec_valid keep their values. Fetch may still complete into the hold buffer. No instruction is lost or duplicated.
- Redirect has highest priority and overrides stall. In the cycle redirect=1:
  - pc<=redirect_pc & ~3.
  - fetch_dec_reg<={NOP_INSTR, 32'h0}, fetch_dec_valid<=0.
  - In REQ without gnt: stay REQ; the next cycle's imem_addr is the new pc.
  - In REQ with gnt the same cycle: the accepted request is stale; drop<=1, go WAIT, pc still takes redirect_pc (no +4).
  - In WAIT: drop<=1, stay WAIT. If rvalid arrives the same cycle, discard it, drop<=0, go REQ.
  - In HOLD: discard the hold buffer, go REQ.
  - In IDLE: pc loaded, go REQ.
- imem_rvalid outside WAIT is a protocol violation. It is ignored and flagged by a bench assertion.
- Throughput: minimum 2 cycles per instruction (REQ+WAIT) with zero-wait memory.
- Widths: pc arithmetic is 32-bit unsigned, wrapping.

Decomposition:
- Shared package fetch_pkg containing:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
  - NOP_INSTR constant
  - FETCH_DEC_WIDTH=64
- One sub-module, pc_gen: PC register with reset load, +4 on grant, and redirect load (redirect wins). It also exports req_pc capture.
- The FSM, drop flag, hold buffer and output register stay in fetch_stage.

Test Plan:
- Zero-wait memory (gnt same cycle as req, rvalid next cycle), words 0x00500093, 0x00A00113:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - fetch_dec_reg = {0x00500093, 0x0}, then {0x00A00113, 0x4}, with valid=1 each.
- Stall=1 asserted before rvalid for address 0x4, held 3 cycles:
  - fetch_dec_reg holds {instr0, 0x0}.
  - After stall drops, the next cycle shows {instr1, 0x4}.
  - Next imem_addr is 0x8; no duplicate, no skip.
- Redirect to 0x100 while in WAIT for address 0x8:
  - fetch_dec_reg={0x00000013, 0x0}, valid=0.
  - The returned data for 0x8 is discarded.
  - Next imem_addr=0x100, and 0x104 follows.
- Redirect to 0x203 coincident with stall=1 and with gnt in REQ:
  - Bubble inserted (valid=0), drop set.
  - Next request address is 0x200.
- RESET_PC=0xFFFF_FFFC: after one grant, imem_addr=0x0000_0000 (wrap).
- rst pulsed while in WAIT, with rvalid arriving the following cycle:
  - Outputs return to reset values, rvalid is ignored.
  - The first request after reset is at RESET_PC.
